// File: rtl/rv_lsu_pkg.sv
// Shared types and constants for the load/store writeback stage.
package rv_lsu_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } lsu_state_t;

   localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
   localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
   localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
   localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

   // funct3[1:0] gives the access size; funct3[2] selects zero-extension for loads
   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      return ((funct3[1:0] == SIZE_H) && addr_lo[0]) ||
             ((funct3[1:0] == SIZE_W) && (addr_lo != 2'b00));
   endfunction

endpackage

// File: rtl/rv_load_fmt.sv
// Combinational load formatter: picks the byte/halfword lane from the bus word
// by address offset and sign- or zero-extends it to 32 bits.
module rv_load_fmt
   import rv_lsu_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addr_lo,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = i_rdata[7:0];
      case (i_addr_lo)
         2'd0:    lane_b = i_rdata[7:0];
         2'd1:    lane_b = i_rdata[15:8];
         2'd2:    lane_b = i_rdata[23:16];
         default: lane_b = i_rdata[31:24];
      endcase
      lane_h = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

      o_data = i_rdata;
      case (i_funct3)
         F3_LB:   o_data = {{24{lane_b[7]}}, lane_b};
         F3_LBU:  o_data = {24'h0, lane_b};
         F3_LH:   o_data = {{16{lane_h[15]}}, lane_h};
         F3_LHU:  o_data = {16'h0, lane_h};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/rv_lsu.sv
// Load/store + writeback stage: non-mem ops and traps retire 1 cycle after acceptance, bus ops 1 cycle after ack.
// o_ready drops for the whole bus transaction; the request is held until ack or timeout, even across a flush.
module rv_lsu
   import rv_lsu_pkg::*;
#(
   parameter int DADDR_SPACE_BITS = 32,
   parameter int BUS_TIMEOUT      = 0
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_flush,
   input  logic                        i_valid,
   input  logic                        i_load,
   input  logic                        i_store,
   input  logic                        i_reg_write,
   input  logic [4:0]                  i_rd,
   input  logic [31:0]                 i_result,
   input  logic [31:0]                 i_addr,
   input  logic [31:0]                 i_wdata,
   input  logic [3:0]                  i_wsel,
   input  logic [2:0]                  i_funct3,
   input  logic                        i_to_trap,
   output logic                        o_ready,
   output logic                        o_dbus_req,
   output logic                        o_dbus_we,
   output logic [DADDR_SPACE_BITS-1:0] o_dbus_addr,
   output logic [31:0]                 o_dbus_wdata,
   output logic [3:0]                  o_dbus_sel,
   input  logic                        i_dbus_ack,
   input  logic [31:0]                 i_dbus_rdata,
   output logic                        o_wb_valid,
   output logic                        o_wb_we,
   output logic [4:0]                  o_wb_rd,
   output logic [31:0]                 o_wb_data,
   output logic                        o_trap,
   output logic [3:0]                  o_trap_cause,
   output logic [31:0]                 o_trap_tval
);

   localparam int CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

   lsu_state_t  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        flushed_q, flushed_d;
   logic [4:0]  rd_q, rd_d;
   logic [2:0]  f3_q, f3_d;
   logic [31:0] addr_q, addr_d;
   logic        ready_q, ready_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  sel_q, sel_d;
   logic        wb_valid_q, wb_valid_d;
   logic        wb_we_q, wb_we_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        trap_q, trap_d;
   logic [3:0]  cause_q, cause_d;
   logic [31:0] tval_q, tval_d;

   logic [31:0] ld_data;
   logic        is_mem;
   logic        misaligned;
   logic        timeout_hit;
   logic        flush_seen;

   rv_load_fmt u_load_fmt (
      .i_rdata   (i_dbus_rdata),
      .i_addr_lo (addr_q[1:0]),
      .i_funct3  (f3_q),
      .o_data    (ld_data)
   );

   always_comb begin
      is_mem      = i_load | i_store;
      misaligned  = is_misaligned(i_funct3, i_addr[1:0]);
      timeout_hit = (BUS_TIMEOUT > 0) && (cnt_q == TO_LAST);
      flush_seen  = flushed_q | i_flush;

      state_d    = state_q;
      cnt_d      = cnt_q;
      flushed_d  = flushed_q;
      rd_d       = rd_q;
      f3_d       = f3_q;
      addr_d     = addr_q;
      ready_d    = ready_q;
      req_d      = req_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      sel_d      = sel_q;
      wb_valid_d = 1'b0;
      wb_we_d    = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      trap_d     = 1'b0;
      cause_d    = cause_q;
      tval_d     = tval_q;

      case (state_q)
         IDLE: begin
            if (i_valid && !i_flush) begin
               if (is_mem && !i_to_trap && !misaligned) begin
                  state_d   = WAIT;
                  ready_d   = 1'b0;
                  req_d     = 1'b1;
                  we_d      = i_store;
                  addr_d    = i_addr;
                  wdata_d   = i_wdata;
                  sel_d     = i_store ? i_wsel : 4'hF;
                  f3_d      = i_funct3;
                  rd_d      = i_rd;
                  cnt_d     = '0;
                  flushed_d = 1'b0;
               end else begin
                  wb_valid_d = 1'b1;
                  wb_rd_d    = i_rd;
                  // An upstream trap has already been reported: retire silently
                  if (!i_to_trap) begin
                     if (is_mem) begin
                        trap_d  = 1'b1;
                        cause_d = i_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
                        tval_d  = i_addr;
                     end else begin
                        wb_we_d   = i_reg_write && (i_rd != 5'd0);
                        wb_data_d = i_result;
                     end
                  end
               end
            end
         end
         WAIT: begin
            if (i_dbus_ack || timeout_hit) begin
               state_d   = IDLE;
               ready_d   = 1'b1;
               req_d     = 1'b0;
               flushed_d = 1'b0;
               if (!flush_seen) begin
                  wb_valid_d = 1'b1;
                  wb_rd_d    = rd_q;
                  // Ack on the limit cycle wins over the timeout
                  if (i_dbus_ack) begin
                     wb_we_d   = !we_q && (rd_q != 5'd0);
                     wb_data_d = we_q ? 32'h0 : ld_data;
                  end else begin
                     trap_d  = 1'b1;
                     cause_d = we_q ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
                     tval_d  = addr_q;
                  end
               end
            end else begin
               cnt_d     = cnt_q + 1'b1;
               flushed_d = flush_seen;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         flushed_q  <= 1'b0;
         rd_q       <= 5'd0;
         f3_q       <= 3'd0;
         addr_q     <= 32'h0;
         ready_q    <= 1'b1;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         wdata_q    <= 32'h0;
         sel_q      <= 4'h0;
         wb_valid_q <= 1'b0;
         wb_we_q    <= 1'b0;
         wb_rd_q    <= 5'd0;
         wb_data_q  <= 32'h0;
         trap_q     <= 1'b0;
         cause_q    <= 4'h0;
         tval_q     <= 32'h0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         flushed_q  <= flushed_d;
         rd_q       <= rd_d;
         f3_q       <= f3_d;
         addr_q     <= addr_d;
         ready_q    <= ready_d;
         req_q      <= req_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         sel_q      <= sel_d;
         wb_valid_q <= wb_valid_d;
         wb_we_q    <= wb_we_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         trap_q     <= trap_d;
         cause_q    <= cause_d;
         tval_q     <= tval_d;
      end
   end

   assign o_ready      = ready_q;
   assign o_dbus_req   = req_q;
   assign o_dbus_we    = we_q;
   assign o_dbus_addr  = addr_q[DADDR_SPACE_BITS-1:0];
   assign o_dbus_wdata = wdata_q;
   assign o_dbus_sel   = sel_q;
   assign o_wb_valid   = wb_valid_q;
   assign o_wb_we      = wb_we_q;
   assign o_wb_rd      = wb_rd_q;
   assign o_wb_data    = wb_data_q;
   assign o_trap       = trap_q;
   assign o_trap_cause = cause_q;
   assign o_trap_tval  = tval_q;

endmodule

// File: tb/tb_rv_lsu.sv
// Directed bench for rv_lsu: vector table for single ops and bus loads/stores, plus hand sequences
// for timeout, flush during a bus wait and reset during a bus wait.
module tb_rv_lsu;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_flush = 1'b0;
   logic        i_valid = 1'b0;
   logic        i_load = 1'b0;
   logic        i_store = 1'b0;
   logic        i_reg_write = 1'b0;
   logic [4:0]  i_rd = 5'd0;
   logic [31:0] i_result = 32'h0;
   logic [31:0] i_addr = 32'h0;
   logic [31:0] i_wdata = 32'h0;
   logic [3:0]  i_wsel = 4'h0;
   logic [2:0]  i_funct3 = 3'd0;
   logic        i_to_trap = 1'b0;
   logic        i_dbus_ack = 1'b0;
   logic [31:0] i_dbus_rdata = 32'h0;
   logic        o_ready, o_dbus_req, o_dbus_we, o_wb_valid, o_wb_we, o_trap;
   logic [31:0] o_dbus_addr, o_dbus_wdata, o_wb_data, o_trap_tval;
   logic [3:0]  o_dbus_sel, o_trap_cause;
   logic [4:0]  o_wb_rd;

   int checks = 0;
   int errors = 0;

   always #5 i_clk = ~i_clk;

   rv_lsu #(.DADDR_SPACE_BITS(32), .BUS_TIMEOUT(8)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid),
      .i_load(i_load), .i_store(i_store), .i_reg_write(i_reg_write), .i_rd(i_rd),
      .i_result(i_result), .i_addr(i_addr), .i_wdata(i_wdata), .i_wsel(i_wsel),
      .i_funct3(i_funct3), .i_to_trap(i_to_trap), .o_ready(o_ready),
      .o_dbus_req(o_dbus_req), .o_dbus_we(o_dbus_we), .o_dbus_addr(o_dbus_addr),
      .o_dbus_wdata(o_dbus_wdata), .o_dbus_sel(o_dbus_sel), .i_dbus_ack(i_dbus_ack),
      .i_dbus_rdata(i_dbus_rdata), .o_wb_valid(o_wb_valid), .o_wb_we(o_wb_we),
      .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data), .o_trap(o_trap),
      .o_trap_cause(o_trap_cause), .o_trap_tval(o_trap_tval)
   );

   typedef struct {
      string       name;
      logic        load, store, rw;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [31:0] addr, val;
      logic [3:0]  wsel;
      logic        to_trap, flush, mem;
      int          dly;
      logic [31:0] rdata;
      logic        e_vld, e_we, e_trap;
      logic [3:0]  e_cause;
      logic [31:0] e_data;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string name, input logic load, store, rw, input logic [4:0] rd,
                               input logic [2:0] f3, input logic [31:0] addr, val, input logic [3:0] wsel,
                               input logic to_trap, flush, mem, input int dly, input logic [31:0] rdata,
                               input logic e_vld, e_we, e_trap, input logic [3:0] e_cause,
                               input logic [31:0] e_data);
      vec_t v;
      v.name = name; v.load = load; v.store = store; v.rw = rw; v.rd = rd; v.f3 = f3;
      v.addr = addr; v.val = val; v.wsel = wsel; v.to_trap = to_trap; v.flush = flush;
      v.mem = mem; v.dly = dly; v.rdata = rdata; v.e_vld = e_vld; v.e_we = e_we;
      v.e_trap = e_trap; v.e_cause = e_cause; v.e_data = e_data;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      i_valid = 1'b1; i_load = v.load; i_store = v.store; i_reg_write = v.rw;
      i_rd = v.rd; i_funct3 = v.f3; i_addr = v.addr; i_result = v.val;
      i_wdata = v.val; i_wsel = v.wsel; i_to_trap = v.to_trap; i_flush = v.flush;
   endtask

   task automatic idle_inputs();
      i_valid = 1'b0; i_load = 1'b0; i_store = 1'b0; i_flush = 1'b0; i_to_trap = 1'b0;
   endtask

   task automatic timeout_seq(input string nm, input logic store, input logic [31:0] addr,
                              input logic [3:0] cause);
      int n;
      @(negedge i_clk);
      i_valid = 1'b1; i_load = !store; i_store = store; i_rd = 5'd4;
      i_funct3 = 3'b010; i_addr = addr; i_wsel = 4'hF; i_to_trap = 1'b0;
      @(negedge i_clk);
      idle_inputs();
      n = 0;
      while (o_dbus_req && n < 20) begin
         n++;
         @(negedge i_clk);
      end
      chk({nm, ".req_cycles"}, n, 8);
      chk({nm, ".req"}, o_dbus_req, 1'b0);
      chk({nm, ".trap"}, o_trap, 1'b1);
      chk({nm, ".cause"}, o_trap_cause, cause);
      chk({nm, ".tval"}, o_trap_tval, addr);
      chk({nm, ".we"}, o_wb_we, 1'b0);
      chk({nm, ".ready"}, o_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int low;
      vec_t v;
      //            name        ld st rw rd     f3      addr          val           wsel  tt fl mem dly rdata          vld we trap cause data
      vecs.push_back(mk("add",      0,0,1,5'd5,3'b000,32'h0,        32'h0000_1234,4'h0,0,0,0,0,32'h0,          1,1,0,4'd0,32'h0000_1234));
      vecs.push_back(mk("rd0",      0,0,1,5'd0,3'b000,32'h0,        32'h0000_0055,4'h0,0,0,0,0,32'h0,          1,0,0,4'd0,32'h0));
      vecs.push_back(mk("nowr",     0,0,0,5'd7,3'b000,32'h0,        32'h0000_0077,4'h0,0,0,0,0,32'h0,          1,0,0,4'd0,32'h0));
      vecs.push_back(mk("sw_mis",   0,1,0,5'd3,3'b010,32'h0000_0201,32'h1111_2222,4'hF,0,0,0,0,32'h0,          1,0,1,4'd6,32'h0000_0201));
      vecs.push_back(mk("lh_mis",   1,0,1,5'd2,3'b001,32'h0000_0101,32'h0,        4'h0,0,0,0,0,32'h0,          1,0,1,4'd4,32'h0000_0101));
      vecs.push_back(mk("lw_mis",   1,0,1,5'd2,3'b010,32'h0000_0102,32'h0,        4'h0,0,0,0,0,32'h0,          1,0,1,4'd4,32'h0000_0102));
      vecs.push_back(mk("to_trap",  1,0,1,5'd2,3'b010,32'h0000_0100,32'h0,        4'h0,1,0,0,0,32'h0,          1,0,0,4'd0,32'h0));
      vecs.push_back(mk("flush_id", 0,0,1,5'd5,3'b000,32'h0,        32'h0000_9999,4'h0,0,1,0,0,32'h0,          0,0,0,4'd0,32'h0));
      vecs.push_back(mk("lb",       1,0,1,5'd3,3'b000,32'h0000_0103,32'h0,        4'h0,0,0,1,3,32'h80AA_BBCC,  1,1,0,4'd0,32'hFFFF_FF80));
      vecs.push_back(mk("lhu",      1,0,1,5'd6,3'b101,32'h0000_0102,32'h0,        4'h0,0,0,1,0,32'hBEEF_0000,  1,1,0,4'd0,32'h0000_BEEF));
      vecs.push_back(mk("lbu",      1,0,1,5'd7,3'b100,32'h0000_0101,32'h0,        4'h0,0,0,1,1,32'h1122_8344,  1,1,0,4'd0,32'h0000_0083));
      vecs.push_back(mk("lh",       1,0,1,5'd8,3'b001,32'h0000_0100,32'h0,        4'h0,0,0,1,2,32'h0000_8001,  1,1,0,4'd0,32'hFFFF_8001));
      vecs.push_back(mk("lw_limit", 1,0,1,5'd9,3'b010,32'h0000_0108,32'h0,        4'h0,0,0,1,7,32'h0102_0304,  1,1,0,4'd0,32'h0102_0304));
      vecs.push_back(mk("lw_rd0",   1,0,1,5'd0,3'b010,32'h0000_0104,32'h0,        4'h0,0,0,1,0,32'hDEAD_BEEF,  1,0,0,4'd0,32'h0));
      vecs.push_back(mk("sw",       0,1,0,5'd1,3'b010,32'h0000_0200,32'hCAFE_F00D,4'hF,0,0,1,1,32'h0,          1,0,0,4'd0,32'h0));
      vecs.push_back(mk("sb",       0,1,0,5'd1,3'b000,32'h0000_0203,32'hAB00_0000,4'h8,0,0,1,2,32'h0,          1,0,0,4'd0,32'h0));

      repeat (2) @(negedge i_clk);
      chk("rst.ready", o_ready, 1'b1);
      chk("rst.req", o_dbus_req, 1'b0);
      chk("rst.wb_valid", o_wb_valid, 1'b0);
      chk("rst.trap", o_trap, 1'b0);
      i_reset = 1'b0;

      foreach (vecs[i]) begin
         v = vecs[i];
         @(negedge i_clk);
         chk({v.name, ".pre_idle"}, o_wb_valid, 1'b0);
         drive(v);
         @(negedge i_clk);
         idle_inputs();
         if (v.mem) begin
            chk({v.name, ".req"}, o_dbus_req, 1'b1);
            chk({v.name, ".bus_we"}, o_dbus_we, v.store);
            chk({v.name, ".bus_addr"}, o_dbus_addr, v.addr);
            chk({v.name, ".bus_sel"}, o_dbus_sel, v.store ? v.wsel : 4'hF);
            if (v.store) chk({v.name, ".bus_wdata"}, o_dbus_wdata, v.val);
            low = 0;
            for (int k = 0; k <= v.dly; k++) begin
               if (k > 0) @(negedge i_clk);
               if (!o_ready) low++;
            end
            i_dbus_ack = 1'b1;
            i_dbus_rdata = v.rdata;
            @(negedge i_clk);
            i_dbus_ack = 1'b0;
            chk({v.name, ".ready_low"}, low, v.dly + 1);
         end else begin
            chk({v.name, ".no_req"}, o_dbus_req, 1'b0);
         end
         if (!v.e_trap) chk({v.name, ".wb_valid"}, o_wb_valid, v.e_vld);
         chk({v.name, ".wb_we"}, o_wb_we, v.e_we);
         chk({v.name, ".trap"}, o_trap, v.e_trap);
         chk({v.name, ".ready"}, o_ready, 1'b1);
         if (v.e_vld && !v.flush) chk({v.name, ".wb_rd"}, o_wb_rd, v.rd);
         if (v.e_we) chk({v.name, ".wb_data"}, o_wb_data, v.e_data);
         if (v.e_trap) begin
            chk({v.name, ".cause"}, o_trap_cause, v.e_cause);
            chk({v.name, ".tval"}, o_trap_tval, v.e_data);
         end
      end

      timeout_seq("to_lw", 1'b0, 32'h0000_0300, 4'd5);
      timeout_seq("to_sw", 1'b1, 32'h0000_0304, 4'd7);

      // Flush while the store is on the bus: handshake completes, beat suppressed
      @(negedge i_clk);
      i_valid = 1'b1; i_store = 1'b1; i_load = 1'b0; i_funct3 = 3'b010;
      i_addr = 32'h0000_0400; i_wdata = 32'h5555_AAAA; i_wsel = 4'hF; i_rd = 5'd1;
      @(negedge i_clk);
      idle_inputs();
      i_flush = 1'b1;
      @(negedge i_clk);
      i_flush = 1'b0;
      chk("flw.req_held", o_dbus_req, 1'b1);
      chk("flw.ready", o_ready, 1'b0);
      @(negedge i_clk);
      chk("flw.req_held2", o_dbus_req, 1'b1);
      i_dbus_ack = 1'b1;
      @(negedge i_clk);
      i_dbus_ack = 1'b0;
      chk("flw.wb_valid", o_wb_valid, 1'b0);
      chk("flw.trap", o_trap, 1'b0);
      chk("flw.req_drop", o_dbus_req, 1'b0);
      chk("flw.ready_back", o_ready, 1'b1);

      // Asynchronous reset in the middle of a bus wait
      @(negedge i_clk);
      i_valid = 1'b1; i_load = 1'b1; i_funct3 = 3'b010; i_addr = 32'h0000_0500; i_rd = 5'd2;
      @(negedge i_clk);
      idle_inputs();
      chk("rstw.req", o_dbus_req, 1'b1);
      i_reset = 1'b1;
      #1;
      chk("rstw.req_drop", o_dbus_req, 1'b0);
      chk("rstw.ready", o_ready, 1'b1);
      @(negedge i_clk);
      i_reset = 1'b0;
      @(negedge i_clk);
      chk("rstw.wb_valid", o_wb_valid, 1'b0);
      chk("rstw.req_idle", o_dbus_req, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
